// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: difference = a - b - borrow_in, computed
//   LSB first, one bit per clock, over WIDTH cycles. A start/busy/done
//   handshake controls it. The result is held until the next accepted start.
//
//   Optional feature macro: SUBTRACTOR_OVERFLOW_EN adds the overflow_o port,
//   which reports signed overflow of the subtraction.
//
//   Ports:
//     clk_i         rising-edge clock
//     rst_ni        asynchronous active-low reset
//     start_i       request, sampled only while not busy (IDLE or DONE)
//     a_i, b_i      minuend / subtrahend, captured on the accepting edge
//     borrow_in_i   initial borrow, captured on the accepting edge
//     busy_o        high while bits are being processed
//     done_o        one-cycle pulse when the result becomes valid
//     difference_o  result, held until the next accepted start
//     borrow_out_o  final borrow (a < b + borrow_in)
//     overflow_o    signed overflow (only with SUBTRACTOR_OVERFLOW_EN)
module serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] difference_o,
  output logic             borrow_out_o
`ifdef SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             overflow_o
`else
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
`ifdef SUBTRACTOR_OVERFLOW_EN
  logic             ov_q, ov_d;
`else
`endif

  // Current bit slice: operands are shifted right, so bit 0 is always the
  // bit being processed this cycle.
  logic bit_a, bit_b, d_bit, br_next;
  assign bit_a   = a_q[0];
  assign bit_b   = b_q[0];
  assign d_bit   = bit_a ^ bit_b ^ br_q;
  assign br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
`ifdef SUBTRACTOR_OVERFLOW_EN
    ov_d    = ov_q;
`else
`endif
    case (state_q)
      // DONE accepts a new request exactly like IDLE for back-to-back use.
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          state_d = SHIFT;
          a_d     = a_i;
          b_d     = b_i;
          br_d    = borrow_in_i;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_next;
        // Result bits enter from the MSB side so that after WIDTH shifts
        // bit 0 has landed in position 0.
        res_d = {d_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bo_d    = br_next;
`ifdef SUBTRACTOR_OVERFLOW_EN
          // On the last bit, bit_a/bit_b are the operand sign bits and
          // d_bit is the result sign bit.
          ov_d    = (bit_a != bit_b) && (d_bit != bit_a);
`else
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
`ifdef SUBTRACTOR_OVERFLOW_EN
      ov_q    <= 1'b0;
`else
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
`ifdef SUBTRACTOR_OVERFLOW_EN
      ov_q    <= ov_d;
`else
`endif
    end
  end

  // Status outputs are pure decodes of the state register.
  assign busy_o       = (state_q == SHIFT);
  assign done_o       = (state_q == DONE);
  assign difference_o = diff_q;
  assign borrow_out_o = bo_q;
`ifdef SUBTRACTOR_OVERFLOW_EN
  assign overflow_o   = ov_q;
`else
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed bench for serial_subtractor (WIDTH = 6). A cycle-level model
//   derived from plain arithmetic predicts every output each cycle; a compare
//   process checks the DUT against it on every falling edge, and each
//   scenario also checks hand-computed literal results and Done latency.
//   Honours SUBTRACTOR_OVERFLOW_EN for the overflow output.
module tb_serial_subtractor;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bo;
  logic [W-1:0] diff;
`ifdef SUBTRACTOR_OVERFLOW_EN
  logic         ov;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .a_i         (a),
    .b_i         (b),
    .borrow_in_i (bin),
    .busy_o      (busy),
    .done_o      (done),
    .difference_o(diff),
    .borrow_out_o(bo)
`ifdef SUBTRACTOR_OVERFLOW_EN
    ,
    .overflow_o  (ov)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation runs for W edges after acceptance, then
  // the arithmetic result appears for one Done cycle.
  logic         m_busy = 0, m_done = 0, m_bo = 0, m_ov = 0;
  logic [W-1:0] m_diff = '0, m_a = '0, m_b = '0;
  logic         m_bin = 0;
  int           m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_diff = '0; m_bo = 0; m_ov = 0; m_left = 0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        m_diff = W'((int'(m_a) - int'(m_b) - int'(m_bin)) & ((1 << W) - 1));
        m_bo   = (int'(m_a) < int'(m_b) + int'(m_bin));
        m_ov   = (m_a[W-1] != m_b[W-1]) && (m_diff[W-1] != m_a[W-1]);
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_busy = 1; m_left = W; m_a = a; m_b = b; m_bin = bin;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 32'(busy), 32'(m_busy));
    check("cyc_done", 32'(done), 32'(m_done));
    check("cyc_diff", 32'(diff), 32'(m_diff));
    check("cyc_bo", 32'(bo), 32'(m_bo));
`ifdef SUBTRACTOR_OVERFLOW_EN
    check("cyc_ov", 32'(ov), 32'(m_ov));
`endif
  end

  // Called #1 after the accepting edge; waits (bounded) for Done.
  task automatic wait_done(input string nm);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no done within 40 cycles", nm);
    end else begin
      check({nm, "_latency"}, 32'(n), 32'(W));
      check({nm, "_busy_in_done"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin, input bit hold);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1;
    @(posedge clk); #1;
    check({nm, "_busy_rise"}, 32'(busy), 32'd1);
    if (!hold) start = 0;
    wait_done(nm);
  endtask

  task automatic check_result(input string nm, input logic [W-1:0] ed, input logic ebo,
                              input logic eov);
    check({nm, "_diff"}, 32'(diff), 32'(ed));
    check({nm, "_bo"}, 32'(bo), 32'(ebo));
`ifdef SUBTRACTOR_OVERFLOW_EN
    check({nm, "_ov"}, 32'(ov), 32'(eov));
`else
    if (eov === 1'bx) $display("unexpected x");
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    rst_n = 1;

    run_op("t1", 6'b101011, 6'b000000, 1'b1, 0);
    check_result("t1", 6'b101010, 1'b0, 1'b0);

    run_op("t2", 6'b000000, 6'b000001, 1'b0, 0);
    check_result("t2", 6'b111111, 1'b1, 1'b0);

    run_op("t3", 6'b011111, 6'b100001, 1'b0, 0);
    check_result("t3", 6'b111110, 1'b1, 1'b1);

    run_op("t5", 6'b100000, 6'b000001, 1'b0, 0);
    check_result("t5", 6'b011111, 1'b0, 1'b1);

    // Start held high: pulses during SHIFT ignored, re-accepted from DONE.
    run_op("t4a", 6'b111111, 6'b111111, 1'b1, 1);
    check_result("t4a", 6'b111111, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("t4_busy_after_done", 32'(busy), 32'd1);
    check("t4_done_low", 32'(done), 32'd0);
    wait_done("t4b");
    check_result("t4b", 6'b111111, 1'b1, 1'b0);
    start = 0;
    @(posedge clk); #1;
    check("t4_idle", 32'(busy), 32'd0);

    // Reset during bit 3 of an operation.
    @(negedge clk);
    a = 6'b000110; b = 6'b011100; bin = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bo", 32'(bo), 32'd0);
`ifdef SUBTRACTOR_OVERFLOW_EN
    check("rst_ov", 32'(ov), 32'd0);
`endif
    @(negedge clk); #2 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("rst_no_done", 32'(done), 32'd0);
    end

    run_op("t6", 6'b000000, 6'b000000, 1'b0, 0);
    check_result("t6", 6'b000000, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end
endmodule
